// File: rtl/seg7_bcd_display.sv
// Binary-to-BCD converter (serial double dabble) with a multiplexed 7-segment scanner.
// Latency: BW cycles from load acceptance to result; done_o pulses for one cycle after that.
// Backpressure: load_i is dropped (not queued) while busy_o is high; the scanner never stalls.
//
// Ports:
//   clk_i, rst_i      clock and synchronous active-high reset
//   value_i, load_i   binary value and capture request
//   busy_o, done_o    conversion in progress / one-cycle result-valid pulse
//   ovf_o             last result did not fit in DIGITS decimal digits
//   bcd_o             packed BCD result, digit 0 (ones) in bits [3:0]
//   seg_o, dig_sel_o  active-high segments (bit0=a) and one-hot digit enable
module seg7_bcd_display #(
   parameter int BW       = 8,
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 1000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [BW-1:0]         value_i,
   input  logic                  load_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  ovf_o,
   output logic [4*DIGITS-1:0]   bcd_o,
   output logic [6:0]            seg_o,
   output logic [DIGITS-1:0]     dig_sel_o
);

   localparam int SW  = 4 * DIGITS;
   localparam int CW  = (BW > 1) ? $clog2(BW) : 1;
   localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic {IDLE, CONV} state_t;

   state_t           state_q;
   logic [BW-1:0]    bin_q;
   logic [SW-1:0]    scratch_q;
   logic [CW-1:0]    cnt_q;
   logic             ovf_acc_q;
   logic [SW-1:0]    bcd_q;
   logic             ovf_q;
   logic             done_q;
   logic [SCW-1:0]   scan_cnt_q;
   logic [IW-1:0]    dig_idx_q;

   // One double-dabble step: adjust every digit, then shift {scratch, binary} left.
   logic [SW-1:0]    adj;
   logic [SW-1:0]    scratch_d;
   logic [BW-1:0]    bin_d;
   logic             ovf_d;

   always_comb begin
      adj = scratch_q;
      for (int d = 0; d < DIGITS; d++) begin
         if (scratch_q[4*d +: 4] >= 4'd5) begin
            adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
         end
      end
      scratch_d = {adj[SW-2:0], bin_q[BW-1]};
      bin_d     = bin_q << 1;
      // Whatever leaves the top digit is a value that did not fit.
      ovf_d     = ovf_acc_q | adj[SW-1];
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         bin_q     <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         ovf_acc_q <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (load_i) begin
                  bin_q     <= value_i;
                  scratch_q <= '0;
                  cnt_q     <= '0;
                  ovf_acc_q <= 1'b0;
                  state_q   <= CONV;
               end
            end
            CONV: begin
               bin_q     <= bin_d;
               scratch_q <= scratch_d;
               ovf_acc_q <= ovf_d;
               cnt_q     <= cnt_q + 1'b1;
               if (cnt_q == CW'(BW - 1)) begin
                  bcd_q   <= scratch_d;
                  ovf_q   <= ovf_d;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Digit scanner runs free of the converter.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         scan_cnt_q <= '0;
         dig_idx_q  <= '0;
      end else if (scan_cnt_q == SCW'(SCAN_DIV - 1)) begin
         scan_cnt_q <= '0;
         if (dig_idx_q == IW'(DIGITS - 1)) begin
            dig_idx_q <= '0;
         end else begin
            dig_idx_q <= dig_idx_q + 1'b1;
         end
      end else begin
         scan_cnt_q <= scan_cnt_q + 1'b1;
      end
   end

   logic [3:0] nib;

   always_comb begin
      nib       = 4'd0;
      dig_sel_o = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (dig_idx_q == IW'(i)) begin
            nib          = bcd_q[4*i +: 4];
            dig_sel_o[i] = 1'b1;
         end
      end
   end

   always_comb begin
      case (nib)
         4'd0:    seg_o = 7'h3F;
         4'd1:    seg_o = 7'h06;
         4'd2:    seg_o = 7'h5B;
         4'd3:    seg_o = 7'h4F;
         4'd4:    seg_o = 7'h66;
         4'd5:    seg_o = 7'h6D;
         4'd6:    seg_o = 7'h7D;
         4'd7:    seg_o = 7'h07;
         4'd8:    seg_o = 7'h7F;
         4'd9:    seg_o = 7'h6F;
         default: seg_o = 7'h00;
      endcase
   end

   assign busy_o = (state_q == CONV);
   assign done_o = done_q;
   assign ovf_o  = ovf_q;
   assign bcd_o  = bcd_q;

endmodule

// File: tb/tb_seg7_bcd_display.sv
module tb_seg7_bcd_display;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [7:0]  value_i;
   logic        load_i;
   logic        busy_o, done_o, ovf_o;
   logic [11:0] bcd_o;
   logic [6:0]  seg_o;
   logic [2:0]  dig_sel_o;

   logic [7:0]  value2;
   logic        load2;
   logic        busy2, done2, ovf2;
   logic [7:0]  bcd2;
   logic [6:0]  seg2;
   logic [1:0]  sel2;

   int vec  = 0;
   int miss = 0;

   always #5 clk = ~clk;

   seg7_bcd_display #(.BW(8), .DIGITS(3), .SCAN_DIV(4)) dut (
      .clk_i(clk), .rst_i(rst_i), .value_i(value_i), .load_i(load_i),
      .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o), .bcd_o(bcd_o),
      .seg_o(seg_o), .dig_sel_o(dig_sel_o)
   );

   seg7_bcd_display #(.BW(8), .DIGITS(2), .SCAN_DIV(4)) dut2 (
      .clk_i(clk), .rst_i(rst_i), .value_i(value2), .load_i(load2),
      .busy_o(busy2), .done_o(done2), .ovf_o(ovf2), .bcd_o(bcd2),
      .seg_o(seg2), .dig_sel_o(sel2)
   );

   // Stimulus helper: called at a negedge, presents one load and observes 16 cycles.
   task automatic run_conv(input logic [7:0] v, output int busy_cnt, output int done_cnt,
                           output int bcd_chg);
      logic [11:0] start_bcd;
      start_bcd = bcd_o;
      value_i   = v;
      load_i    = 1'b1;
      busy_cnt  = 0;
      done_cnt  = 0;
      bcd_chg   = 0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         load_i = 1'b0;
         if (busy_o) busy_cnt++;
         if (done_o) done_cnt++;
         if (busy_o && bcd_o !== start_bcd) bcd_chg++;
      end
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst_i = 1'b1;
      repeat (2) @(negedge clk);
      vec++; if (busy_o !== 1'b0) begin miss++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      vec++; if (done_o !== 1'b0) begin miss++; $display("FAIL reset_done got=%b exp=0", done_o); end
      vec++; if (ovf_o !== 1'b0) begin miss++; $display("FAIL reset_ovf got=%b exp=0", ovf_o); end
      vec++; if (bcd_o !== 12'h000) begin miss++; $display("FAIL reset_bcd got=%h exp=000", bcd_o); end
      vec++; if (dig_sel_o !== 3'b001) begin miss++; $display("FAIL reset_sel got=%b exp=001", dig_sel_o); end
      vec++; if (seg_o !== 7'h3F) begin miss++; $display("FAIL reset_seg got=%h exp=3F", seg_o); end
      rst_i = 1'b0;
   endtask

   task automatic test_convert_255;
      int b, d, c;
      run_conv(8'd255, b, d, c);
      vec++; if (b !== 8) begin miss++; $display("FAIL c255_busy_cycles got=%0d exp=8", b); end
      vec++; if (d !== 1) begin miss++; $display("FAIL c255_done_pulses got=%0d exp=1", d); end
      vec++; if (c !== 0) begin miss++; $display("FAIL c255_bcd_stable got=%0d exp=0", c); end
      vec++; if (bcd_o !== 12'h255) begin miss++; $display("FAIL c255_bcd got=%h exp=255", bcd_o); end
      vec++; if (ovf_o !== 1'b0) begin miss++; $display("FAIL c255_ovf got=%b exp=0", ovf_o); end
   endtask

   // Starts right after reset so the scan phase is known: n = edges since reset.
   task automatic test_scan;
      int b, d, c, n, idx;
      logic [2:0] exp_sel;
      logic [6:0] exp_seg;
      @(negedge clk);
      rst_i = 1'b1;
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      run_conv(8'd255, b, d, c);
      n = 16;
      for (int k = 0; k < 24; k++) begin
         idx     = (n / 4) % 3;
         exp_sel = (idx == 0) ? 3'b001 : (idx == 1) ? 3'b010 : 3'b100;
         exp_seg = (idx == 2) ? 7'h5B : 7'h6D;
         vec++; if (dig_sel_o !== exp_sel || seg_o !== exp_seg) begin
            miss++;
            $display("FAIL scan n=%0d got sel=%b seg=%h exp sel=%b seg=%h",
                     n, dig_sel_o, seg_o, exp_sel, exp_seg);
         end
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_ignore_load;
      int dn;
      int guard;
      value_i = 8'd171;
      load_i  = 1'b1;
      dn      = 0;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         load_i  = (i == 3);
         value_i = (i == 3) ? 8'd0 : 8'd171;
         if (done_o) dn++;
      end
      vec++; if (done_o !== 1'b1) begin miss++; $display("FAIL ign_done_at_9 got=%b exp=1", done_o); end
      vec++; if (dn !== 1) begin miss++; $display("FAIL ign_done_pulses got=%0d exp=1", dn); end
      vec++; if (bcd_o !== 12'h171) begin miss++; $display("FAIL ign_bcd got=%h exp=171", bcd_o); end
      // Load during the done cycle must be accepted.
      value_i = 8'd42;
      load_i  = 1'b1;
      @(negedge clk);
      load_i = 1'b0;
      vec++; if (busy_o !== 1'b1) begin miss++; $display("FAIL ign_load_in_done got busy=%b exp=1", busy_o); end
      guard = 0;
      while (!done_o && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      vec++; if (guard >= 20) begin miss++; $display("FAIL ign_second_done timeout got=%0d exp<20", guard); end
      vec++; if (bcd_o !== 12'h042) begin miss++; $display("FAIL ign_second_bcd got=%h exp=042", bcd_o); end
   endtask

   task automatic conv2(input logic [7:0] v);
      value2 = v;
      load2  = 1'b1;
      @(negedge clk);
      load2 = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_overflow;
      conv2(8'd123);
      vec++; if (bcd2 !== 8'h23) begin miss++; $display("FAIL ovf123_bcd got=%h exp=23", bcd2); end
      vec++; if (ovf2 !== 1'b1) begin miss++; $display("FAIL ovf123_flag got=%b exp=1", ovf2); end
      conv2(8'd99);
      vec++; if (bcd2 !== 8'h99) begin miss++; $display("FAIL ovf99_bcd got=%h exp=99", bcd2); end
      vec++; if (ovf2 !== 1'b0) begin miss++; $display("FAIL ovf99_flag got=%b exp=0", ovf2); end
      vec++; if (seg2 !== 7'h6F) begin miss++; $display("FAIL ovf99_seg got=%h exp=6F", seg2); end
      vec++; if (!$onehot(sel2)) begin miss++; $display("FAIL ovf99_sel got=%b exp=onehot", sel2); end
   endtask

   task automatic test_reset_abort;
      int dn, chg, b, d, c;
      value_i = 8'd200;
      load_i  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         load_i = 1'b0;
      end
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      vec++; if (busy_o !== 1'b0) begin miss++; $display("FAIL abort_busy got=%b exp=0", busy_o); end
      dn  = 0;
      chg = 0;
      for (int i = 0; i < 12; i++) begin
         if (done_o) dn++;
         if (bcd_o !== 12'h000) chg++;
         @(negedge clk);
      end
      vec++; if (dn !== 0) begin miss++; $display("FAIL abort_done got=%0d exp=0", dn); end
      vec++; if (chg !== 0) begin miss++; $display("FAIL abort_bcd_nonzero got=%0d exp=0", chg); end
      run_conv(8'd200, b, d, c);
      vec++; if (bcd_o !== 12'h200) begin miss++; $display("FAIL abort_reload_bcd got=%h exp=200", bcd_o); end
      vec++; if (d !== 1) begin miss++; $display("FAIL abort_reload_done got=%0d exp=1", d); end
   endtask

   initial begin
      rst_i   = 1'b1;
      value_i = '0;
      load_i  = 1'b0;
      value2  = '0;
      load2   = 1'b0;
      test_reset();
      test_convert_255();
      test_scan();
      test_ignore_load();
      test_overflow();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule

// File: doc/seg7_bcd_display.md
SEG7_BCD_DISPLAY -- requirements
Module: seg7_bcd_display

Interface
REQ-001 SHALL have parameter BW, default 8: bit width of the binary value to display.
REQ-002 SHALL have parameter DIGITS, default 3: number of decimal digits converted and scanned.
REQ-003 SHALL have parameter SCAN_DIV, default 1000: clock cycles each digit is driven (minimum 1).
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset; synchronous, active-high.
REQ-006 SHALL have port value_i  input  BW  unsigned binary value, typically a counter output.
REQ-007 SHALL have port load_i  input  1  request to capture value_i and start conversion.
REQ-008 SHALL have port busy_o  output  1  conversion in progress; load_i ignored while high.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse: new result on bcd_o.
REQ-010 SHALL have port ovf_o  output  1  last result exceeded 10^DIGITS-1.
REQ-011 SHALL have port bcd_o  output  4*DIGITS  packed BCD result; digit 0 (ones) in bits [3:0].
REQ-012 SHALL have port seg_o  output  7  active-high segments, bit0=a ... bit6=g, for the selected digit.
REQ-013 SHALL have port dig_sel_o  output  DIGITS  one-hot digit enable, bit i = digit i.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and CONV; busy_o = (state == CONV).
REQ-015 SHALL, in IDLE with load_i=1 at edge k, capture value_i into a shift register, clear BCD scratch and shift counter, and enter CONV.
REQ-016 SHALL perform one double-dabble iteration per edge k+1 .. k+BW: add 3 to every scratch digit >= 5, then shift {scratch, binary} left by one.
REQ-017 SHALL use a 4*DIGITS-bit scratch; any 1 shifted out of the scratch MSB sets an internal overflow flag for that conversion.
REQ-018 SHALL, at edge k+BW, write the final scratch to bcd_o, the overflow flag to ovf_o, return to IDLE, and assert done_o for exactly the following cycle.
REQ-019 SHALL give busy_o high for exactly BW cycles per conversion; bcd_o and ovf_o are unchanged while busy_o is high.
REQ-020 SHALL ignore load_i while in CONV, with no queuing. Load is accepted in the cycle done_o is high, since the state is IDLE then.
REQ-021 SHALL, on overflow, hold value_i mod 10^DIGITS in bcd_o.
REQ-022 SHALL run a scan counter 0..SCAN_DIV-1 continuously, independent of the FSM. On wrap it SHALL advance the digit index 0..DIGITS-1, wrapping to 0.
REQ-023 SHALL drive dig_sel_o as the one-hot of the digit index, combinationally from registered state.
REQ-024 SHALL decode seg_o from the bcd_o nibble at the digit index: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, 10-15=0x00.
REQ-025 SHALL update seg_o in the same cycle that bcd_o changes.

Reset
REQ-026 SHALL, when rst_i=1 at an edge, set state=IDLE, busy_o=0, done_o=0, ovf_o=0, bcd_o=0, scan counter=0, digit index=0. This gives dig_sel_o=1 and seg_o=0x3F.
REQ-027 SHALL give rst_i priority over load_i and over an in-progress conversion; an aborted conversion never asserts done_o or updates bcd_o.

Verification
REQ-028 SHALL cover: hold rst_i 2 cycles -> busy_o=0, done_o=0, ovf_o=0, bcd_o=12'h000, dig_sel_o=3'b001, seg_o=7'h3F.
REQ-029 SHALL cover: load value_i=255 -> busy_o high 8 cycles, then done_o pulses once, bcd_o=12'h255, ovf_o=0.
REQ-030 SHALL cover: load 171, then load_i=1 with value_i=0 on the 3rd busy cycle -> bcd_o=12'h171, a single done_o pulse, and a load in the done_o cycle is accepted.
REQ-031 SHALL cover: DIGITS=2, load 123 -> bcd_o=8'h23, ovf_o=1. Then load 99 -> bcd_o=8'h99, ovf_o=0.
REQ-032 SHALL cover: SCAN_DIV=4, bcd_o=12'h255 -> dig_sel_o/seg_o sequence 001/0x6D, 010/0x6D, 100/0x5B, each for 4 cycles, then wraps to 001.
REQ-033 SHALL cover: assert rst_i on the 4th cycle of converting 200 -> no done_o, bcd_o=0. A subsequent load of 200 yields bcd_o=12'h200.
